tx_gen_crc: RTL and testbench
=============================

// Module: tx_gen_crc
// PURPOSE
//  - Host-bound test-data source. Each command produces one block: a generated payload followed by its CRC32.
//  - The block is emitted as an AXI-stream into the ftdi_245fifo_top TX port.
//  - It is the send-side counterpart of the receive/CRC-check path, so the host can verify the USB IN direction.
// PARAMETERS
//  - OEW  default 2   output width exponent; o_tdata = 8<<OEW bits, 2^OEW byte lanes (OEW 0..4)
// PORTS
//  - clk       in   1         single clock; all logic on posedge
//  - rstn      in   1         synchronous active-low reset
//  - i_tvalid  in   1         command valid
//  - i_tready  out  1         command accept; high only in IDLE
//  - i_len     in   16        payload length in bytes (0..65535)
//  - i_seed    in   8         first payload byte, taken mod 255
//  - o_tready  in   1         downstream ready
//  - o_tvalid  out  1         output beat valid
//  - o_tdata   out  8<<OEW    output bytes; lane 0 = bits[7:0] = earliest byte
//  - o_tkeep   out  1<<OEW    lane enables; contiguous from lane 0
//  - o_tlast   out  1         final beat of block
//  - o_busy    out  1         block in progress
//  - o_blk_cnt out  16        completed-block counter; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset values: i_tready=1, o_tvalid=0, o_tdata=0, o_tkeep=0, o_tlast=0, o_busy=0, o_blk_cnt=0; state=IDLE.
//  - Command: accepted on i_tvalid&&i_tready. Latch len and byte b0 = (i_seed==8'hFF) ? 8'h00 : i_seed.
//  - Payload: byte i+1 = (byte i == 8'hFE) ? 8'h00 : byte i + 1. 0xFF never appears in the payload.
//  - CRC32 (IEEE, reflected): poly 0xEDB88320, init 0xFFFFFFFF, xorout 0xFFFFFFFF.
//    - Computed over the payload bytes only.
//    - Appended little-endian, LSB byte first.
//  - Block stream: len payload bytes, then 4 CRC bytes, packed contiguously across lanes (no gaps).
//    - The CRC may share a beat with the tail of the payload.
//    - The CRC update chains combinationally through the payload lanes of a beat, in lane order.
//  - Beat count = ceil(total/2^OEW). All beats have full tkeep except possibly the last one.
//  - FSM states:
//    - IDLE -> EMIT on command accept.
//    - EMIT -> DONE when the tlast beat is accepted.
//    - DONE -> IDLE next cycle: o_blk_cnt++ and i_tready reasserts. Min 1 idle cycle between blocks.
//  - Latency: command accepted in cycle N -> first beat has o_tvalid=1 in cycle N+1.
//  - Handshake: outputs registered. While o_tvalid && !o_tready, o_tdata/o_tkeep/o_tlast hold stable.
//    - The next beat loads in the same cycle the current beat is accepted, so throughput is 1 beat/cycle.
//  - Commands are ignored while busy (i_tready=0). No queuing.
//  - len=0: the output is the CRC only, which is 0x00000000.
//  - Byte counter is 17 bits, so the len+4 / len+5 totals do not overflow at len=65535.
//  - rstn low mid-block: abort with no tlast. All outputs return to reset values on the next edge.
// CONFIGURATION
//  - TX_GEN_CRC_TERM_EN defined: append one 0xFF terminator byte after the CRC, total = len+5.
//    - This matches the host's delimiter convention.
//  - Not defined: total = len+4. No 0xFF is ever emitted except inside the CRC bytes.
// TESTING (OEW=2 unless noted)
//  - T1: len=9, seed=0x31 ("123456789"), o_tready=1.
//    - Expect 4 beats: 0x34333231/1111, 0x38373635/1111, 0xF4392639/1111, 0x000000CB/0001 with tlast.
//    - CRC=0xCBF43926.
//  - T2: same as T1 with TERM_EN defined.
//    - Expect last beat 0x0000FFCB/0011 with tlast.
//  - T3: len=0. Expect a single beat 0x00000000/1111 with tlast. o_blk_cnt increments to 1.
//  - T4: len=1, seed=0x31.
//    - Expect 0xDCEFB731/1111, then 0x00000083/0001 with tlast (CRC=0x83DCEFB7).
//    - Repeat with seed=0xFD, len=4: payload bytes FD FE 00 01.
//    - Repeat with seed=0xFF: b0=0x00.
//  - T5: T1 with o_tready low for 5 cycles on beat 2, and i_tvalid held high during the block.
//    - Expect beat 2 held stable and no command accepted until DONE.
//    - Output otherwise identical to T1.
//  - T6: rstn low for 1 cycle during beat 2 of a len=100 block.
//    - Expect o_tvalid=0 and i_tready=1 after reset.
//    - A new len=1 command then yields exactly the T4 output.

Source files
------------

// File: rtl/tx_gen_crc_if.sv
// Command and AXI-stream output bundle for tx_gen_crc.
// master = command issuer / stream consumer, slave = the generator.
interface tx_gen_crc_if #(
  parameter int unsigned OEW = 2
);
  localparam int unsigned DW = 8 << OEW;
  localparam int unsigned KW = 1 << OEW;

  logic          i_tvalid;
  logic          i_tready;
  logic [15:0]   i_len;
  logic [7:0]    i_seed;
  logic          o_tready;
  logic          o_tvalid;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic          o_tlast;
  logic          o_busy;
  logic [15:0]   o_blk_cnt;

  modport master (
    output i_tvalid, i_len, i_seed, o_tready,
    input  i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast, o_busy, o_blk_cnt
  );

  modport slave (
    input  i_tvalid, i_len, i_seed, o_tready,
    output i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast, o_busy, o_blk_cnt
  );
endinterface

// File: rtl/tx_gen_crc.sv
// Test-data block source: counting payload followed by its reflected CRC32, as an AXI-stream.
// Define TX_GEN_CRC_TERM_EN to append a 0xFF terminator byte after the CRC.
module tx_gen_crc #(
  parameter int unsigned OEW = 2
) (
  input  logic        clk,
  input  logic        rstn,
  tx_gen_crc_if.slave bus
);
  localparam int unsigned NL = 1 << OEW;
  localparam int unsigned DW = 8 * NL;
`ifdef TX_GEN_CRC_TERM_EN
  localparam int unsigned TAIL = 5;
`else
  localparam int unsigned TAIL = 4;
`endif
  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t        state, state_d;
  logic [15:0]   len_q, len_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic [31:0]   crc_q, crc_d;
  logic          tready_q, tready_d;
  logic          tvalid_q, tvalid_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic [NL-1:0] tkeep_q, tkeep_d;
  logic          tlast_q, tlast_d;
  logic          busy_q, busy_d;
  logic [15:0]   blk_q, blk_d;
  logic          load;

  logic          idle;
  logic [16:0]   g_cnt;
  logic [15:0]   g_len;
  logic [7:0]    g_byte;
  logic [31:0]   g_crc;
  logic [DW-1:0] gen_data;
  logic [NL-1:0] gen_keep;
  logic          gen_last;
  logic [16:0]   gen_cnt;
  logic [7:0]    gen_byte;
  logic [31:0]   gen_crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // First beat is built straight from the command so it appears the cycle after accept.
  assign idle   = (state == IDLE);
  assign g_cnt  = idle ? 17'd0 : cnt_q;
  assign g_len  = idle ? bus.i_len : len_q;
  assign g_byte = idle ? ((bus.i_seed == 8'hFF) ? 8'h00 : bus.i_seed) : byte_q;
  assign g_crc  = idle ? 32'hFFFF_FFFF : crc_q;

  // Next-beat builder: payload lanes advance the CRC in lane order, CRC lanes see the result.
  always_comb begin : gen
    logic [31:0] c;
    logic [7:0]  b;
    logic [16:0] idx;
    logic [16:0] pay;
    logic [16:0] tot;
    logic [1:0]  sel;
    c        = g_crc;
    b        = g_byte;
    pay      = {1'b0, g_len};
    tot      = pay + 17'(TAIL);
    gen_data = '0;
    gen_keep = '0;
    for (int k = 0; k < NL; k++) begin
      idx = g_cnt + 17'(k);
      sel = 2'(idx - pay);
      if (idx < pay) begin
        gen_data[8*k +: 8] = b;
        gen_keep[k]        = 1'b1;
        c = crc_step(c, b);
        b = (b == 8'hFE) ? 8'h00 : b + 8'd1;
      end else if (idx < pay + 17'd4) begin
        gen_data[8*k +: 8] = 8'(~c >> {sel, 3'b000});
        gen_keep[k]        = 1'b1;
      end
`ifdef TX_GEN_CRC_TERM_EN
      else if (idx == pay + 17'd4) begin
        gen_data[8*k +: 8] = 8'hFF;
        gen_keep[k]        = 1'b1;
      end
`endif
    end
    gen_cnt  = g_cnt + 17'(NL);
    gen_last = (gen_cnt >= tot);
    gen_byte = b;
    gen_crc  = c;
  end

  // Next-state and next-output logic.
  always_comb begin : fsm
    state_d  = state;
    len_d    = len_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    crc_d    = crc_q;
    tready_d = tready_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    blk_d    = blk_q;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_tvalid && tready_q) begin
          load     = 1'b1;
          state_d  = EMIT;
          tready_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      EMIT: begin
        if (tvalid_q && bus.o_tready) begin
          if (tlast_q) begin
            state_d  = DONE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        tready_d = 1'b1;
        busy_d   = 1'b0;
        blk_d    = blk_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      len_d    = g_len;
      cnt_d    = gen_cnt;
      byte_d   = gen_byte;
      crc_d    = gen_crc;
      tvalid_d = 1'b1;
      tdata_d  = gen_data;
      tkeep_d  = gen_keep;
      tlast_d  = gen_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      byte_q   <= '0;
      crc_q    <= '0;
      tready_q <= 1'b1;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      blk_q    <= '0;
    end else begin
      state    <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      crc_q    <= crc_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      blk_q    <= blk_d;
    end
  end

  assign bus.i_tready  = tready_q;
  assign bus.o_tvalid  = tvalid_q;
  assign bus.o_tdata   = tdata_q;
  assign bus.o_tkeep   = tkeep_q;
  assign bus.o_tlast   = tlast_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_blk_cnt = blk_q;
endmodule

// File: tb/tb_tx_gen_crc.sv
// Bench for tx_gen_crc (OEW=2): directed vectors plus random blocks against a byte-queue model.
module tb_tx_gen_crc;
  localparam int unsigned OEW = 2;
  localparam int unsigned NL  = 4;
`ifdef TX_GEN_CRC_TERM_EN
  localparam int unsigned TAIL = 5;
`else
  localparam int unsigned TAIL = 4;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  tx_gen_crc_if #(.OEW(OEW)) bus ();
  tx_gen_crc #(.OEW(OEW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int errors = 0;
  int exp_blk = 0;

  logic [31:0] crc_tab [256];
  logic [7:0]  exp_q [$];
  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];
  logic        got_last [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte i of the payload is (b0 + i) mod 255; CRC is table-driven over those bytes.
  task automatic build_model(input int len, input logic [7:0] seed);
    int b0;
    logic [31:0] c;
    logic [7:0] b;
    exp_q.delete();
    b0 = (seed == 8'hFF) ? 0 : int'(seed);
    c  = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      b = 8'((b0 + i) % 255);
      exp_q.push_back(b);
      c = crc_tab[(c ^ {24'h0, b}) & 32'hFF] ^ (c >> 8);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));
    if (TAIL == 5) exp_q.push_back(8'hFF);
  endtask

  task automatic run_block(input int len, input logic [7:0] seed, input int stall_beat,
                           input int stall_n, input bit hold_valid, input bit rnd_stall);
    int nb, n, st, idx;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    build_model(len, seed);
    nb = (exp_q.size() + NL - 1) / NL;
    got_data.delete(); got_keep.delete(); got_last.delete();
    n = 0;
    while (bus.i_tready !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_ready", 64'(bus.i_tready), 64'd1);
    bus.i_tvalid = 1'b1;
    bus.i_len    = 16'(len);
    bus.i_seed   = seed;
    bus.o_tready = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) bus.i_tvalid = 1'b0;
    chk("busy_set", 64'(bus.o_busy), 64'd1);
    chk("cmd_tready_low", 64'(bus.i_tready), 64'd0);
    for (int j = 0; j < nb; j++) begin
      ed = '0; ek = '0;
      for (int k = 0; k < NL; k++) begin
        idx = j * NL + k;
        if (idx < exp_q.size()) begin
          ed[8*k +: 8] = exp_q[idx];
          ek[k] = 1'b1;
        end
      end
      el = (j == nb - 1);
      st = (j == stall_beat) ? stall_n : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      if (st > 0) begin
        bus.o_tready = 1'b0;
        repeat (st) begin
          @(posedge clk); #1;
          chk($sformatf("hold%0d_valid", j), 64'(bus.o_tvalid), 64'd1);
          chk($sformatf("hold%0d_data", j), 64'(bus.o_tdata), 64'(ed));
          chk($sformatf("hold%0d_last", j), 64'(bus.o_tlast), 64'(el));
          chk($sformatf("hold%0d_tready", j), 64'(bus.i_tready), 64'd0);
        end
        bus.o_tready = 1'b1;
      end
      got_data.push_back(bus.o_tdata);
      got_keep.push_back(bus.o_tkeep);
      got_last.push_back(bus.o_tlast);
      chk($sformatf("beat%0d_valid", j), 64'(bus.o_tvalid), 64'd1);
      chk($sformatf("beat%0d_data", j), 64'(bus.o_tdata), 64'(ed));
      chk($sformatf("beat%0d_keep", j), 64'(bus.o_tkeep), 64'(ek));
      chk($sformatf("beat%0d_last", j), 64'(bus.o_tlast), 64'(el));
      @(posedge clk); #1;
    end
    bus.i_tvalid = 1'b0;
    chk("done_valid", 64'(bus.o_tvalid), 64'd0);
    chk("done_tready", 64'(bus.i_tready), 64'd0);
    chk("done_blk", 64'(bus.o_blk_cnt), 64'(exp_blk));
    @(posedge clk); #1;
    exp_blk = (exp_blk + 1) & 16'hFFFF;
    chk("idle_blk", 64'(bus.o_blk_cnt), 64'(exp_blk));
    chk("idle_tready", 64'(bus.i_tready), 64'd1);
    chk("idle_busy", 64'(bus.o_busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    rstn = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.i_len    = '0;
    bus.i_seed   = '0;
    bus.o_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", 64'(bus.i_tready), 64'd1);
    chk("rst_tvalid", 64'(bus.o_tvalid), 64'd0);
    chk("rst_tdata", 64'(bus.o_tdata), 64'd0);
    chk("rst_tkeep", 64'(bus.o_tkeep), 64'd0);
    chk("rst_tlast", 64'(bus.o_tlast), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_blk", 64'(bus.o_blk_cnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // T1: "123456789"
    run_block(9, 8'h31, -1, 0, 1'b0, 1'b0);
    chk("t1_nbeats", 64'(got_data.size()), 64'd4);
    chk("t1_b0", 64'(got_data[0]), 64'h34333231);
    chk("t1_b1", 64'(got_data[1]), 64'h38373635);
    chk("t1_b2", 64'(got_data[2]), 64'hF4392639);
`ifdef TX_GEN_CRC_TERM_EN
    chk("t1_b3", 64'(got_data[3]), 64'h0000FFCB);
    chk("t1_k3", 64'(got_keep[3]), 64'h3);
`else
    chk("t1_b3", 64'(got_data[3]), 64'h000000CB);
    chk("t1_k3", 64'(got_keep[3]), 64'h1);
`endif
    chk("t1_l3", 64'(got_last[3]), 64'd1);

    // T3: empty payload
    run_block(0, 8'h55, -1, 0, 1'b0, 1'b0);
    chk("t3_b0", 64'(got_data[0]), 64'h00000000);
    chk("t3_k0", 64'(got_keep[0]), 64'hF);
    chk("t3_blk", 64'(bus.o_blk_cnt), 64'd2);

    // T4 and its seed variants
    run_block(1, 8'h31, -1, 0, 1'b0, 1'b0);
    chk("t4_b0", 64'(got_data[0]), 64'hDCEFB731);
`ifdef TX_GEN_CRC_TERM_EN
    chk("t4_b1", 64'(got_data[1]), 64'h0000FF83);
`else
    chk("t4_b1", 64'(got_data[1]), 64'h00000083);
`endif
    run_block(4, 8'hFD, -1, 0, 1'b0, 1'b0);
    chk("t4_fd_b0", 64'(got_data[0]), 64'h0100FEFD);
    run_block(1, 8'hFF, -1, 0, 1'b0, 1'b0);
    chk("t4_ff_b0", 64'(got_data[0] & 32'hFF), 64'h00);

    // T5: stall on beat 2 with command held valid
    run_block(9, 8'h31, 1, 5, 1'b1, 1'b0);
    chk("t5_b1", 64'(got_data[1]), 64'h38373635);
    chk("t5_b2", 64'(got_data[2]), 64'hF4392639);

    // Random blocks with random backpressure
    for (int r = 0; r < 12; r++)
      run_block(int'($urandom_range(0, 40)), 8'($urandom_range(0, 255)), -1, 0, 1'b0, 1'b1);
    run_block(300, 8'hF0, -1, 0, 1'b0, 1'b1);

    // T6: reset during beat 2 of a len=100 block
    bus.i_tvalid = 1'b1;
    bus.i_len    = 16'd100;
    bus.i_seed   = 8'h10;
    bus.o_tready = 1'b1;
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0;
    @(posedge clk); #1;
    chk("t6_beat2_valid", 64'(bus.o_tvalid), 64'd1);
    chk("t6_beat2_data", 64'(bus.o_tdata), 64'h17161514);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_blk = 0;
    chk("t6_valid", 64'(bus.o_tvalid), 64'd0);
    chk("t6_tready", 64'(bus.i_tready), 64'd1);
    chk("t6_tlast", 64'(bus.o_tlast), 64'd0);
    chk("t6_busy", 64'(bus.o_busy), 64'd0);
    chk("t6_blk", 64'(bus.o_blk_cnt), 64'd0);
    run_block(1, 8'h31, -1, 0, 1'b0, 1'b0);
    chk("t6_b0", 64'(got_data[0]), 64'hDCEFB731);
    chk("t6_nbeats", 64'(got_data.size()), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
